// File: rtl/sram_1p_req_ctrl_if.sv
// Request/response bundle between an upstream client and sram_1p_req_ctrl.
// Valid/ready: a request transfers on a rising clock edge where valid and ready are both high;
// r_resp_valid is a one-cycle strobe with no back-pressure.
interface sram_1p_req_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 5
);
  logic              w_req_valid;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_data;
  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  modport master (
    output w_req_valid, w_req_addr, w_req_data, r_req_valid, r_req_addr,
    input  w_req_ready, r_req_ready, r_resp_valid, r_resp_data
  );

  modport slave (
    input  w_req_valid, w_req_addr, w_req_data, r_req_valid, r_req_addr,
    output w_req_ready, r_req_ready, r_resp_valid, r_resp_data
  );
endinterface

// File: rtl/sram_1p_req_ctrl.sv
// Front-end for a single-port masked SRAM: zero-fills the array after reset, then
// arbitrates write/read requests onto RW0 (write wins) and returns read data one cycle later.
module sram_1p_req_ctrl #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_1p_req_ctrl_if.slave req,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic              sram_wmask,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One extra bit so the counter never has to wrap to signal completion.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              init_done_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] hold_q;
  logic              w_ready, r_ready;
  logic              w_fire, r_fire;
  logic              clr_last;

  assign clr_last = (state_q == ST_INIT) && (clr_cnt_q == CLR_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) begin
        state_q     <= ST_INIT;
        init_done_q <= 1'b0;
      end else begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
      end
      clr_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      resp_valid_q <= r_fire;
      if (clr_last) begin
        init_done_q <= 1'b1;
      end
      if (resp_valid_q) begin
        hold_q <= sram_rdata;
      end
    end
  end

  // Readies and the RW0 strobes are gated by reset_n so nothing is offered while reset is held.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    w_fire     = 1'b0;
    r_fire     = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_wmask = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (reset_n) begin
      case (state_q)
        ST_INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_wmask = 1'b1;
          sram_addr  = clr_cnt_q[ADDR_W-1:0];
          clr_cnt_d  = clr_cnt_q + CLR_ONE;
          if (clr_last) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          w_ready = 1'b1;
          r_ready = !req.w_req_valid;
          w_fire  = req.w_req_valid;
          r_fire  = req.r_req_valid && !req.w_req_valid;
          if (w_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_wmask = 1'b1;
            sram_addr  = req.w_req_addr;
            sram_wdata = req.w_req_data;
          end else if (r_fire) begin
            sram_en   = 1'b1;
            sram_addr = req.r_req_addr;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  assign req.w_req_ready  = w_ready;
  assign req.r_req_ready  = r_ready;
  assign req.r_resp_valid = resp_valid_q;
  // Macro output is only trusted in the response cycle; otherwise replay the captured word.
  assign req.r_resp_data  = resp_valid_q ? sram_rdata : hold_q;
  assign init_done        = init_done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// Bench for sram_1p_req_ctrl: behavioural SRAM macro, memory reference model,
// expected-response queue popped by a monitor, directed and random request traffic.
module tb_sram_1p_req_ctrl;

  logic       clock;
  logic       reset_n;
  logic       init_done;
  logic       sram_en, sram_wmode, sram_wmask;
  logic [9:0] sram_addr;
  logic [4:0] sram_wdata;
  logic [4:0] sram_rdata;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic [4:0] ref_mem [1024];
  logic [4:0] macro_mem [1024];

  sram_1p_req_ctrl_if #(.ADDR_W(10), .DATA_W(5)) bus ();

  sram_1p_req_ctrl #(
    .DEPTH(1024), .ADDR_W(10), .DATA_W(5), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // single-port macro: masked write, registered read data
  always @(posedge clock) begin
    if (sram_en && sram_wmode && sram_wmask) macro_mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wmode) sram_rdata <= macro_mem[sram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expectation per response, otherwise checks the held value
  task automatic monitor();
    logic [4:0] hold_exp = '0;
    logic [4:0] e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold_exp = '0;
      end else if (bus.r_resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(bus.r_resp_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", 32'(bus.r_resp_data), 32'(e));
          hold_exp = e;
        end
      end else begin
        check("hold_data", 32'(bus.r_resp_data), 32'(hold_exp));
      end
    end
  endtask

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
    return 10'($urandom_range(0, 15));
  endfunction

  // driver: one clock of requests, called at posedge+1
  task automatic cycle(input bit wv, input logic [9:0] wa, input logic [4:0] wd,
                       input bit rv, input logic [9:0] ra, output bit rf);
    bit wf;
    logic [17:0] bus_exp;
    bus.w_req_valid = wv;
    bus.w_req_addr  = wa;
    bus.w_req_data  = wd;
    bus.r_req_valid = rv;
    bus.r_req_addr  = ra;
    wf = wv;
    rf = rv && !wv;
    @(negedge clock);
    check("w_req_ready", 32'(bus.w_req_ready), 32'd1);
    check("r_req_ready", 32'(bus.r_req_ready), 32'(!wv));
    if (wf)      bus_exp = {3'b111, wa, wd};
    else if (rf) bus_exp = {3'b100, ra, 5'd0};
    else         bus_exp = '0;
    check("sram_bus", 32'({sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata}), 32'(bus_exp));
    if (rf) exp_q.push_back(ref_mem[ra]);
    if (wf) ref_mem[wa] = wd;
    @(posedge clock);
    #1;
    bus.w_req_valid = 1'b0;
    bus.r_req_valid = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [4:0] d);
    bit rf;
    cycle(1'b1, a, d, 1'b0, 10'd0, rf);
  endtask

  task automatic rd(input logic [9:0] a);
    bit rf;
    cycle(1'b0, 10'd0, 5'd0, 1'b1, a, rf);
  endtask

  task automatic idle(input int n);
    bit rf;
    for (int i = 0; i < n; i++) cycle(1'b0, 10'd0, 5'd0, 1'b0, 10'd0, rf);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({bus.w_req_ready, bus.r_req_ready, init_done, bus.r_resp_valid,
                     bus.r_resp_data, sram_en}), 32'd0);
  endtask

  // clear sequence after reset release; abort_at >= 0 asserts reset at that clear address
  task automatic clear_seq(input int abort_at);
    bus.w_req_valid = 1'b1;
    bus.r_req_valid = 1'b1;
    bus.w_req_addr  = pick_addr();
    bus.w_req_data  = 5'($urandom);
    bus.r_req_addr  = pick_addr();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clock);
      check("clear_bus", 32'({sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata}),
            32'({3'b111, 10'(i), 5'd0}));
      check("clear_ready", 32'({bus.w_req_ready, bus.r_req_ready, init_done}), 32'd0);
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_clear");
        bus.w_req_valid = 1'b0;
        bus.r_req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        return;
      end
    end
    @(negedge clock);
    check("init_done_rise", 32'(init_done), 32'd1);
    check("ready_after_init", 32'({bus.w_req_ready, bus.r_req_ready}), 32'b10);
    bus.w_req_valid = 1'b0;
    bus.r_req_valid = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit rpend, rf, wv;
    logic [9:0] ra, wa;
    logic [4:0] wd;
    reset_n = 1'b0;
    bus.w_req_valid = 1'b0;
    bus.r_req_valid = 1'b0;
    bus.w_req_addr  = '0;
    bus.w_req_data  = '0;
    bus.r_req_addr  = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    reset_n = 1'b1;
    clear_seq(-1);

    // cleared location reads zero
    rd(10'h2A5);
    idle(1);
    // write then read, then hold
    wr(10'h3FF, 5'h15);
    rd(10'h3FF);
    idle(6);
    // same-cycle conflict: write wins, read retried next cycle
    cycle(1'b1, 10'h010, 5'h0A, 1'b1, 10'h010, rf);
    rd(10'h010);
    idle(1);
    // stream
    for (int i = 0; i < 8; i++) wr(10'(i), 5'(i + 1));
    for (int i = 0; i < 8; i++) rd(10'(i));
    idle(2);
    // read then overwrite
    wr(10'h100, 5'h03);
    idle(1);
    rd(10'h100);
    wr(10'h100, 5'h1F);
    idle(4);

    // random traffic; a stalled read stays pending until accepted
    rpend = 1'b0;
    ra = '0;
    for (int k = 0; k < 400; k++) begin
      wv = ($urandom_range(0, 99) < 40);
      if (!rpend) begin
        rpend = ($urandom_range(0, 99) < 60);
        ra = pick_addr();
      end
      wa = pick_addr();
      wd = 5'($urandom);
      cycle(wv, wa, wd, rpend, ra, rf);
      if (rf) rpend = 1'b0;
    end
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // reset during RUN, then reset again mid-clear
    wr(10'h155, 5'h1B);
    rd(10'h155);
    idle(2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_run");
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_seq(500);
    clear_seq(-1);
    rd(10'h155);
    rd(10'h3FF);
    idle(2);
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
